// File: rtl/conv_pool_top.sv
// rtl/conv_pool_top.sv - two-layer streaming CNN front end: C1 conv, max pool, C2 conv, lane burst
module conv_pool_top #(
  parameter int N = 3,
  parameter int BitSize = 4,
  parameter int ImageWidth = 8,
  parameter int Stride = 2,
  parameter int C1CyclesPerPixel = 2,
  parameter int C1NumberOfK = 4,
  parameter int C1KernelBitSize = 2,
  parameter logic [C1KernelBitSize*N*N-1:0] C1kernel [C1NumberOfK-1:0] = '{default: '0},
  parameter int C2CyclesPerPixel = 4,
  parameter int C2NumberOfK = 8,
  parameter int C2KernelBitSize = 4,
  parameter int C2ProcessingElements = 2,
  parameter logic [C2KernelBitSize*N*N-1:0] C2kernel [C2NumberOfK-1:0] = '{default: '0}
) (
  input  logic                                           clk,
  input  logic                                           res_n,
  input  logic                                           in_valid,
  input  logic [BitSize-1:0]                             in_data,
  output logic                                           out_ready,
  output logic [C2NumberOfK-1:0]                         out_valid,
  output logic [C2ProcessingElements-1:0][BitSize-1:0]   out_data
);

  localparam int NN = N * N;
  localparam int C1PE = C1NumberOfK / C1CyclesPerPixel;
  localparam int PE2 = C2ProcessingElements;
  localparam int C2PerCh = C2NumberOfK / C1NumberOfK;
  localparam int SRLEN = (N - 1) * ImageWidth + N;
  localparam int CW = $clog2(ImageWidth);
  localparam int PHW = (C1CyclesPerPixel > 1) ? $clog2(C1CyclesPerPixel) : 1;
  localparam int BW = (C2CyclesPerPixel > 1) ? $clog2(C2CyclesPerPixel) : 1;
  localparam int SMAX = 2 ** (BitSize - 1) - 1;
  localparam int SMIN = -(2 ** (BitSize - 1));

  typedef enum logic [2:0] {S_RUN, S_WAIT, S_C2, S_BURST, S_END} state_t;
  state_t state, state_next;

  logic [PHW-1:0]     phase;
  logic [CW-1:0]      row, col, c1_r, c1_c;
  logic               c1_active;
  logic [PHW-1:0]     c1_step;
  logic [BW-1:0]      bcnt;
  logic [BitSize-1:0] sr [SRLEN];
  logic [BitSize-1:0] pool [C1NumberOfK][NN];
  logic [BitSize-1:0] c2_res [C2NumberOfK];

  logic               accept, last_pix;
  int                 c1_acc, c2_acc, oi, oj, pool_idx;
  int                 c1_k [C1PE];
  logic [BitSize-1:0] c1_val [C1PE];
  logic [BitSize-1:0] c2_val [C2NumberOfK];
  logic               pool_hit, pool_first;

  function automatic logic [BitSize-1:0] sat(input int v);
    if (v > SMAX) return BitSize'(SMAX);
    if (v < SMIN) return BitSize'(SMIN);
    return BitSize'(v);
  endfunction

  assign accept = in_valid && out_ready;
  assign last_pix = (row == CW'(ImageWidth - 1)) && (col == CW'(ImageWidth - 1));

  always_ff @(posedge clk) begin
    if (!res_n) state <= S_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RUN:   if (accept && last_pix) state_next = S_WAIT;
      S_WAIT:  if (c1_active && c1_step == PHW'(C1CyclesPerPixel - 1)) state_next = S_C2;
      S_C2:    state_next = S_BURST;
      S_BURST: if (bcnt == BW'(C2CyclesPerPixel - 1)) state_next = S_END;
      S_END:   state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  // Window bottom-right is the newest pixel sr[0]; each step serves C1PE kernels.
  always_comb begin
    c1_acc = 0;
    for (int p = 0; p < C1PE; p++) begin
      c1_k[p] = int'(c1_step) * C1PE + p;
      c1_acc = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          c1_acc += int'($signed(sr[(N-1-i)*ImageWidth + (N-1-j)])) *
                    int'($signed(C1kernel[c1_k[p]][C1KernelBitSize*(NN-1-(i*N+j)) +: C1KernelBitSize]));
      c1_val[p] = sat(c1_acc);
    end
  end

  always_comb begin
    oi = int'(c1_r) - (N - 1);
    oj = int'(c1_c) - (N - 1);
    pool_hit = (oi >= 0) && (oj >= 0) && (oi / Stride < N) && (oj / Stride < N);
    pool_first = (oi % Stride == 0) && (oj % Stride == 0);
    pool_idx = pool_hit ? (oi / Stride) * N + oj / Stride : 0;
  end

  always_comb begin
    c2_acc = 0;
    for (int k = 0; k < C2NumberOfK; k++) begin
      c2_acc = 0;
      for (int i = 0; i < NN; i++)
        c2_acc += int'($signed(pool[k/C2PerCh][i])) *
                  int'($signed(C2kernel[k][C2KernelBitSize*(NN-1-i) +: C2KernelBitSize]));
      c2_val[k] = sat(c2_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      out_ready <= 1'b0;
      out_valid <= '0;
      out_data  <= '0;
      phase     <= '0;
      row       <= '0;
      col       <= '0;
      c1_r      <= '0;
      c1_c      <= '0;
      c1_active <= 1'b0;
      c1_step   <= '0;
      bcnt      <= '0;
      for (int i = 0; i < SRLEN; i++) sr[i] <= '0;
      for (int c = 0; c < C1NumberOfK; c++)
        for (int i = 0; i < NN; i++) pool[c][i] <= '0;
      for (int k = 0; k < C2NumberOfK; k++) c2_res[k] <= '0;
    end else begin
      // Ready is held off for the whole frame tail and restarts on phase 0.
      if (state_next == S_RUN) begin
        out_ready <= (phase == '0);
        phase <= (phase == PHW'(C1CyclesPerPixel - 1)) ? '0 : phase + 1'b1;
      end else begin
        out_ready <= 1'b0;
        phase <= '0;
      end

      if (c1_active) begin
        if (pool_hit)
          for (int p = 0; p < C1PE; p++)
            if (pool_first || ($signed(c1_val[p]) > $signed(pool[c1_k[p]][pool_idx])))
              pool[c1_k[p]][pool_idx] <= c1_val[p];
        c1_step <= c1_step + 1'b1;
        if (c1_step == PHW'(C1CyclesPerPixel - 1)) c1_active <= 1'b0;
      end

      if (accept) begin
        for (int i = SRLEN - 1; i > 0; i--) sr[i] <= sr[i-1];
        sr[0]     <= in_data;
        c1_r      <= row;
        c1_c      <= col;
        c1_active <= 1'b1;
        c1_step   <= '0;
        if (col == CW'(ImageWidth - 1)) begin
          col <= '0;
          row <= last_pix ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (state == S_C2) begin
        for (int k = 0; k < C2NumberOfK; k++) c2_res[k] <= c2_val[k];
        bcnt <= '0;
      end

      if (state == S_BURST) begin
        for (int p = 0; p < PE2; p++) out_data[p] <= c2_res[int'(bcnt)*PE2 + p];
        out_valid <= C2NumberOfK'({PE2{1'b1}}) << (int'(bcnt) * PE2);
        bcnt <= bcnt + 1'b1;
      end else begin
        out_valid <= '0;
        out_data  <= '0;
      end

      if (state == S_END) begin
        row  <= '0;
        col  <= '0;
        bcnt <= '0;
        for (int i = 0; i < SRLEN; i++) sr[i] <= '0;
        for (int c = 0; c < C1NumberOfK; c++)
          for (int i = 0; i < NN; i++) pool[c][i] <= '0;
        for (int k = 0; k < C2NumberOfK; k++) c2_res[k] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_conv_pool_top.sv
// tb/tb_conv_pool_top.sv - directed bench: two kernel sets driven by one pixel stream
module tb_conv_pool_top;

  logic clk = 1'b0;
  logic res_n, in_valid;
  logic [3:0] in_data;
  logic ready_a, ready_b;
  logic [7:0] valid_a, valid_b;
  logic [1:0][3:0] data_a, data_b;

  always #5 clk = ~clk;

  // A: every C1 weight +1, every C2 weight +1.
  conv_pool_top #(
    .C1kernel('{18'h15555, 18'h15555, 18'h15555, 18'h15555}),
    .C2kernel('{36'h111111111, 36'h111111111, 36'h111111111, 36'h111111111,
                36'h111111111, 36'h111111111, 36'h111111111, 36'h111111111})
  ) dut_a (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
    .out_ready(ready_a), .out_valid(valid_a), .out_data(data_a)
  );

  // B: only C1 kernel 3 (top-left +1); C2 kernel 6 = {w00=1, w11=2, w22=-1}.
  conv_pool_top #(
    .C1kernel('{18'h10000, 18'h00000, 18'h00000, 18'h00000}),
    .C2kernel('{36'h111111111, 36'h10002000F, 36'h111111111, 36'h111111111,
                36'h111111111, 36'h111111111, 36'h111111111, 36'h111111111})
  ) dut_b (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
    .out_ready(ready_b), .out_valid(valid_b), .out_data(data_b)
  );

  int n_assert = 0;
  int n_fail = 0;
  logic [3:0] img [64];
  logic [3:0] pv [9];
  logic [3:0] exp_a [8];
  logic [3:0] exp_b [8];
  bit chk_a, chk_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic send_frame(input int npix, input bit gaps);
    int idx = 0;
    int guard = 0;
    bit acc;
    logic prev_ready = 1'b0;
    @(posedge clk); #1;
    while (idx < npix && guard < 4000) begin
      in_data = img[idx];
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (!gaps && guard > 0) check("ready_alternates", ready_a, !prev_ready);
      prev_ready = ready_a;
      acc = ready_a && in_valid;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    in_data = 4'h0;
    check("pixels_accepted", idx, npix);
  endtask

  task automatic get_burst();
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (valid_a == 8'h00 && lat < 40);
    check("burst_latency", lat, 5);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      check($sformatf("valid_a_c%0d", b), valid_a, 32'h3 << (2 * b));
      check($sformatf("valid_b_c%0d", b), valid_b, 32'h3 << (2 * b));
      check("ready_low_in_burst", ready_a, 1'b0);
      for (int p = 0; p < 2; p++) begin
        if (chk_a) check($sformatf("lane_a_k%0d", 2 * b + p), data_a[p], exp_a[2*b+p]);
        if (chk_b) check($sformatf("lane_b_k%0d", 2 * b + p), data_b[p], exp_b[2*b+p]);
      end
    end
    @(negedge clk);
    check("valid_after_burst", valid_a, 8'h00);
    check("data_after_burst", data_a, 8'h00);
    check("ready_after_burst", ready_a, 1'b1);
  endtask

  initial begin
    int seen;
    res_n = 1'b0;
    in_valid = 1'b0;
    in_data = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", ready_a, 1'b0);
    check("reset_valid", valid_a, 8'h00);
    check("reset_data", data_a, 8'h00);
    check("reset_valid_b", valid_b, 8'h00);
    res_n = 1'b1;
    @(negedge clk); check("ready_pre_release", ready_a, 1'b0);
    @(negedge clk); check("ready_first", ready_a, 1'b1);
    @(negedge clk); check("ready_second", ready_a, 1'b0);
    @(negedge clk); check("ready_third", ready_a, 1'b1);

    // Zero image: both sets produce 0 everywhere.
    for (int i = 0; i < 64; i++) img[i] = 4'h0;
    for (int k = 0; k < 8; k++) begin exp_a[k] = 4'h0; exp_b[k] = 4'h0; end
    chk_a = 1'b1; chk_b = 1'b1;
    send_frame(64, 1'b0);
    get_burst();

    // All ones: C1 9->7, pool 7, C2 63->7.
    for (int i = 0; i < 64; i++) img[i] = 4'h1;
    for (int k = 0; k < 8; k++) exp_a[k] = 4'h7;
    chk_b = 1'b0;
    send_frame(64, 1'b0);
    get_burst();

    // All -8: C1 -72->-8, pool -8, C2 -72->-8.
    for (int i = 0; i < 64; i++) img[i] = 4'h8;
    for (int k = 0; k < 8; k++) exp_a[k] = 4'h8;
    send_frame(64, 1'b0);
    get_burst();

    // One maximum per pooling window on a -8 background; pooled grid = pv.
    pv = '{4'h1, 4'h2, 4'h3, 4'h0, 4'hF, 4'h2, 4'h1, 4'h0, 4'hE};
    for (int i = 0; i < 64; i++) img[i] = 4'h8;
    for (int pr = 0; pr < 3; pr++)
      for (int pc = 0; pc < 3; pc++)
        img[(2 * pr + ((pr + pc) & 1)) * 8 + 2 * pc + (pc & 1)] = pv[pr*3+pc];
    exp_b = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h6};
    chk_a = 1'b0; chk_b = 1'b1;
    send_frame(64, 1'b0);
    get_burst();

    // Same image with in_valid dropped on random cycles.
    send_frame(64, 1'b1);
    get_burst();

    // Abort after 30 pixels, then a full clean frame.
    send_frame(30, 1'b0);
    res_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_ready", ready_a, 1'b0);
    check("midreset_valid", valid_a, 8'h00);
    res_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid_a != 8'h00 || valid_b != 8'h00) seen++;
    end
    check("no_burst_after_abort", seen, 0);
    send_frame(64, 1'b0);
    get_burst();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
